// File: rtl/loader_pkg.sv
// Shared types and sizing for the operand loader.
// Holds the FSM state encoding and the frame geometry constants.
// Optional checksum state is present only when LOADER_CHECKSUM_EN is defined.
package loader_pkg;

    localparam int A_N       = 16;
    localparam int B_N       = 9;
    localparam int FRAME_LEN = A_N + B_N;
    localparam int CK_IDX    = 25;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
`ifdef LOADER_CHECKSUM_EN
        ST_CHECK,
`endif
        ST_FIRE,
        ST_HOLD
    } loader_state_t;

endpackage

// File: rtl/loader_xor_acc.sv
// Running XOR of the operand bytes of one frame, used for the checksum compare.
// Latency: acc_o reflects every byte written up to and including the previous edge.
// No backpressure: updates whenever en_i is high, clears while clr_i is high.
module loader_xor_acc #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic [DW-1:0] dat_i,
    output logic [DW-1:0] acc_o
);

    logic [DW-1:0] acc_q;
    logic [DW-1:0] acc_d;
    logic [DW-1:0] base;

    // Clear takes effect before the fold, so the first byte accepted in IDLE
    // seeds the accumulator instead of being lost.
    always_comb begin
        base  = clr_i ? '0 : acc_q;
        acc_d = en_i ? (base ^ dat_i) : base;
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/operand_loader.sv
// Byte-serial loader that fills the 4x4 A and 3x3 B operand registers, then pulses run.
// Latency: run is high the cycle after the last frame byte is accepted; matrices are registered.
// Backpressure: in_ready drops in FIRE/HOLD until release_i; optional LOADER_CHECKSUM_EN adds a checksum byte.
module operand_loader #(
    parameter int DW  = 8,
    parameter int A_N = 16,
    parameter int B_N = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [DW-1:0]    in_data,
    output logic             in_ready,
    input  logic             abort,
    input  logic             release_i,
    output logic [A_N*DW-1:0] a_mat,
    output logic [B_N*DW-1:0] b_mat,
    output logic             run,
    output logic             busy,
    output logic [4:0]       load_cnt,
    output logic             err
);

    import loader_pkg::*;

    localparam int FRAME = A_N + B_N;

    loader_state_t state_q, state_d;
    logic [4:0]    cnt_q, cnt_d;
    logic          xfer;
    logic          wr_en;
    logic [DW-1:0] a_q [A_N];
    logic [DW-1:0] b_q [B_N];

`ifdef LOADER_CHECKSUM_EN
    logic          err_q, err_d;
    logic [DW-1:0] xor_acc;
    logic          ck_match;

    loader_xor_acc #(.DW(DW)) u_xor_acc (
        .clk   (clk),
        .reset (reset),
        .clr_i (state_q == ST_IDLE),
        .en_i  (wr_en),
        .dat_i (in_data),
        .acc_o (xor_acc)
    );

    assign ck_match = (xor_acc == in_data);
    assign err      = err_q;
`else
    assign err = 1'b0;
`endif

    assign xfer = in_valid & in_ready;

    // State decodes for the handshake and the controller-facing status.
    always_comb begin
        in_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD)
`ifdef LOADER_CHECKSUM_EN
                   || (state_q == ST_CHECK)
`endif
                   ;
        run  = (state_q == ST_FIRE);
        busy = (state_q == ST_FIRE) || (state_q == ST_HOLD);
    end

    // Next-state, byte counter and write-enable decode; abort beats a same-cycle transfer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    wr_en   = 1'b1;
                    cnt_d   = 5'd1;
                    state_d = ST_LOAD;
`ifdef LOADER_CHECKSUM_EN
                    err_d   = 1'b0;
`endif
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    cnt_d   = 5'd0;
                end else if (xfer) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'(FRAME - 1)) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = ST_CHECK;
`else
                        state_d = ST_FIRE;
`endif
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    cnt_d   = 5'd0;
                end else if (xfer) begin
                    if (ck_match) begin
                        state_d = ST_FIRE;
                        cnt_d   = cnt_q + 5'd1;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = 5'd0;
                        err_d   = 1'b1;
                    end
                end
            end
`endif
            ST_FIRE: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (release_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = 5'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 5'd0;
            end
        endcase
    end

    // FSM state, byte counter and sticky error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
`ifdef LOADER_CHECKSUM_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
`ifdef LOADER_CHECKSUM_EN
            err_q   <= err_d;
`endif
        end
    end

    // Operand registers: the byte counter selects the element; only reset clears them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < A_N; i++) a_q[i] <= '0;
            for (int j = 0; j < B_N; j++) b_q[j] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < A_N; i++) begin
                if (cnt_q == 5'(i)) a_q[i] <= in_data;
            end
            for (int j = 0; j < B_N; j++) begin
                if (cnt_q == 5'(A_N + j)) b_q[j] <= in_data;
            end
        end
    end

    for (genvar gi = 0; gi < A_N; gi++) begin : g_a_pack
        assign a_mat[gi*DW +: DW] = a_q[gi];
    end
    for (genvar gj = 0; gj < B_N; gj++) begin : g_b_pack
        assign b_mat[gj*DW +: DW] = b_q[gj];
    end

    assign load_cnt = cnt_q;

endmodule

// File: tb/tb_operand_loader.sv
// Scoreboarded bench for operand_loader: expected frames are queued on issue and
// popped by an independent monitor whenever run is presented.
// Checksum-specific vectors are compiled in only with LOADER_CHECKSUM_EN.
module tb_operand_loader;

    localparam int DW  = 8;
    localparam int A_N = 16;
    localparam int B_N = 9;
`ifdef LOADER_CHECKSUM_EN
    localparam int LAST_CNT = 26;
`else
    localparam int LAST_CNT = 25;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [DW-1:0]    in_data;
    logic             in_ready;
    logic             abort;
    logic             release_i;
    logic [A_N*DW-1:0] a_mat;
    logic [B_N*DW-1:0] b_mat;
    logic             run;
    logic             busy;
    logic [4:0]       load_cnt;
    logic             err;

    operand_loader #(.DW(DW), .A_N(A_N), .B_N(B_N)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .abort     (abort),
        .release_i (release_i),
        .a_mat     (a_mat),
        .b_mat     (b_mat),
        .run       (run),
        .busy      (busy),
        .load_cnt  (load_cnt),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] a;
        logic [71:0]  b;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    int           passed = 0;
    int           total  = 0;
    int           runs_seen = 0;
    int           runs_exp  = 0;
    logic         prev_run  = 1'b0;
    logic [7:0]   fb [25];
    logic [127:0] a_model;
    logic [71:0]  b_model;

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    endtask

    task automatic chk5(input string nm, input logic [4:0] act, input logic [4:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic chkv(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Monitor: every run pulse must be single-cycle and match the oldest queued frame.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (run === 1'b1) begin
                runs_seen++;
                chk1("run_single_cycle", prev_run, 1'b0);
                if (sb.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_run: run=1 with no frame queued");
                end else begin
                    mon_e = sb.pop_front();
                    chkv("frame_a", a_mat, mon_e.a);
                    chkv("frame_b", 128'(b_mat), 128'(mon_e.b));
                end
            end
            prev_run = run;
        end else begin
            prev_run = 1'b0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic build_model();
        for (int k = 0; k < 16; k++) a_model[k*8 +: 8] = fb[k];
        for (int k = 16; k < 25; k++) b_model[(k-16)*8 +: 8] = fb[k];
    endtask

    // One accepted transfer; returns 1 time unit after the accepting edge.
    task automatic xfer(input logic [7:0] d);
        logic acc;
        int   guard;
        acc   = 1'b0;
        guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!acc && guard < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!acc) begin
            total++;
            $display("FAIL xfer_timeout: in_ready=0 for %0d cycles, required 1", guard);
        end
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input bit gap, input bit bad_ck);
        logic [7:0] ck;
        build_model();
        if (!bad_ck) begin
            exp_t e;
            e.a = a_model;
            e.b = b_model;
            sb.push_back(e);
            runs_exp++;
        end
        ck = 8'h00;
        for (int k = 0; k < 25; k++) begin
            ck = ck ^ fb[k];
            xfer(fb[k]);
            chk5("load_cnt_acc", load_cnt, 5'(k + 1));
            if (k == 0) chk1("err_clear_first_byte", err, 1'b0);
            if (gap && k < 24) begin
                @(posedge clk);
                #1;
                chk5("load_cnt_gap", load_cnt, 5'(k + 1));
            end
        end
`ifdef LOADER_CHECKSUM_EN
        chk1("check_in_ready", in_ready, 1'b1);
        if (bad_ck) ck = ck ^ 8'h01;
        xfer(ck);
`endif
        if (!bad_ck) begin
            chk1("fire_run", run, 1'b1);
            chk1("fire_busy", busy, 1'b1);
            chk1("fire_in_ready", in_ready, 1'b0);
            chk5("fire_load_cnt", load_cnt, 5'(LAST_CNT));
            @(posedge clk);
            #1;
            chk1("hold_run", run, 1'b0);
            chk1("hold_busy", busy, 1'b1);
            chk1("hold_in_ready", in_ready, 1'b0);
        end
    endtask

    task automatic do_release();
        release_i = 1'b1;
        @(posedge clk);
        #1;
        release_i = 1'b0;
        chk1("rel_busy", busy, 1'b0);
        chk5("rel_load_cnt", load_cnt, 5'd0);
        chk1("rel_in_ready", in_ready, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        abort     = 1'b0;
        release_i = 1'b0;
        #1;
        chk1("rst_in_ready", in_ready, 1'b1);
        chkv("rst_a_mat", a_mat, 128'd0);
        chkv("rst_b_mat", 128'(b_mat), 128'd0);
        chk1("rst_run", run, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk5("rst_load_cnt", load_cnt, 5'd0);
        chk1("rst_err", err, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back frame of 1..25.
        for (int k = 0; k < 25; k++) fb[k] = 8'(k + 1);
        send_frame(1'b0, 1'b0);
        chkv("a11", 128'(a_mat[7:0]), 128'(8'd1));
        chkv("a44", 128'(a_mat[127:120]), 128'(8'd16));
        chkv("b11", 128'(b_mat[7:0]), 128'(8'd17));
        chkv("b33", 128'(b_mat[71:64]), 128'(8'd25));

        // HOLD ignores data and abort for 10 cycles.
        in_valid = 1'b1;
        in_data  = 8'hFF;
        abort    = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk1("hold_lock_in_ready", in_ready, 1'b0);
            @(posedge clk);
            #1;
            chk1("hold_lock_busy", busy, 1'b1);
        end
        in_valid = 1'b0;
        abort    = 1'b0;
        chkv("hold_a_frozen", a_mat, a_model);
        chkv("hold_b_frozen", 128'(b_mat), 128'(b_model));
        do_release();

        // Abort on byte 8 after 7 x 0xAA, from a cleared register file.
        do_reset();
        for (int k = 0; k < 7; k++) begin
            if (k == 3) release_i = 1'b1;
            xfer(8'hAA);
            release_i = 1'b0;
        end
        chk5("partial_cnt", load_cnt, 5'd7);
        in_valid = 1'b1;
        in_data  = 8'h55;
        abort    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        abort    = 1'b0;
        chk5("abort_load_cnt", load_cnt, 5'd0);
        chk1("abort_in_ready", in_ready, 1'b1);
        chk1("abort_busy", busy, 1'b0);
        chkv("abort_a24", 128'(a_mat[63:56]), 128'd0);
        chkv("abort_a_mat", a_mat, {72'd0, 56'hAAAAAAAAAAAAAA});
        chkv("abort_b_mat", 128'(b_mat), 128'd0);
        @(posedge clk);
        #1;
        chk1("abort_no_run", run, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        // Bad checksum: back to IDLE with err, no run.
        for (int k = 0; k < 25; k++) fb[k] = 8'(k + 1);
        send_frame(1'b0, 1'b1);
        chk1("ck_bad_err", err, 1'b1);
        chk1("ck_bad_run", run, 1'b0);
        chk1("ck_bad_busy", busy, 1'b0);
        chk1("ck_bad_in_ready", in_ready, 1'b1);
        chk5("ck_bad_load_cnt", load_cnt, 5'd0);
`endif

        // Frame with in_valid low every other cycle.
        for (int k = 0; k < 25; k++) fb[k] = 8'(k + 1);
        send_frame(1'b1, 1'b0);
        do_release();

        // Reset while byte 12 is being offered.
        for (int k = 0; k < 11; k++) xfer(8'(8'h40 + k));
        in_valid = 1'b1;
        in_data  = 8'h4B;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk1("mid_rst_in_ready", in_ready, 1'b1);
        chkv("mid_rst_a_mat", a_mat, 128'd0);
        chkv("mid_rst_b_mat", 128'(b_mat), 128'd0);
        chk1("mid_rst_busy", busy, 1'b0);
        chk5("mid_rst_load_cnt", load_cnt, 5'd0);
        chk1("mid_rst_err", err, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Clean frame after the reset.
        for (int k = 0; k < 25; k++) fb[k] = 8'(8'hC0 + k);
        send_frame(1'b0, 1'b0);
        do_release();

        repeat (3) @(posedge clk);
        #1;
        total++;
        if (runs_seen == runs_exp && sb.size() == 0) passed++;
        else $display("FAIL run_count: saw %0d run pulses, required %0d (%0d frames left)",
                      runs_seen, runs_exp, sb.size());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
